// File: rtl/ext_exit_ctrl_pkg.sv
// ext_exit_pkg
// Shared definitions for the exit controller: the controller state
// encoding, the bit offsets of the fields packed into the result word,
// and the helper that sizes the channel-index field.
package ext_exit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The exit code always sits in the least significant bits of the result word.
  localparam int OFF_CODE = 0;

  // Width of the channel index; a single channel still gets one bit.
  function automatic int calcChw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int offChan(input int ew);
    return ew;
  endfunction

  function automatic int offTimeout(input int ew, input int chw);
    return ew + chw;
  endfunction

  function automatic int offFail(input int ew, input int chw);
    return ew + chw + 1;
  endfunction

  function automatic int offDone(input int ew, input int chw);
    return ew + chw + 2;
  endfunction

  function automatic int outWidth(input int ew, input int chw);
    return ew + chw + 3;
  endfunction

endpackage

// File: rtl/ext_exit_ctrl_chan.sv
// ext_exit_chan
// One exit-request channel: a sticky "finished" flag plus a latch that
// captures the exit code presented on the first accepted request.
// Ports:
//   CLK      - clock, rising edge
//   RST_N    - synchronous active-low reset
//   en       - request acceptance window from the controller
//   finish   - exit request from the hart
//   exitcode - exit code accompanying the request
//   fin      - sticky flag, set by the first accepted request
//   code     - exit code captured with that first request
module ext_exit_chan #(
  parameter int EW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          en,
  input  logic          finish,
  input  logic [EW-1:0] exitcode,
  output logic          fin,
  output logic [EW-1:0] code
);

  // Once fin is set the channel ignores every later request, so the
  // first reported exit code is the one that sticks.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      fin  <= 1'b0;
      code <= '0;
    end else if (en && finish && !fin) begin
      fin  <= 1'b1;
      code <= exitcode;
    end
  end

endmodule

// File: rtl/ext_exit_ctrl.sv
// ext_exit_ctrl
// Collects exit requests from NCH harts, decides when the run is over
// (all channels finished, or any channel finished, depending on MODE),
// waits DRAIN cycles and then raises done with a pass/fail verdict.
// An optional watchdog ends a run that never terminates.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - synchronous active-low reset
//   arg   - per-channel {finish, exitcode}, channel i at [i*(1+EW) +: 1+EW]
//   out   - registered {done, fail, timeout, chan, code}
module ext_exit_ctrl
  import ext_exit_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int EW      = 8,
  parameter  int MODE    = 0,
  parameter  int DRAIN   = 4,
  parameter  int TIMEOUT = 0,
  localparam int CHW     = calcChw(NCH),
  localparam int OW      = outWidth(EW, CHW)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NCH*(1+EW)-1:0] arg,
  output logic [OW-1:0]         out
);

  localparam int          SW         = 1 + EW;
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);
  localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN - 1);

  state_t          r_state;
  logic            r_stop;
  logic            r_done;
  logic            r_fail;
  logic            r_timeout;
  logic [CHW-1:0]  r_chan;
  logic [EW-1:0]   r_code;
  logic [7:0]      r_drainCnt;
  logic [31:0]     r_wdCnt;

  logic            w_en;
  logic [NCH-1:0]  w_finish;
  logic [NCH-1:0]  w_fin;
  logic [NCH-1:0]  w_accept;
  logic [NCH-1:0]  w_finNext;
  logic [NCH-1:0]  w_chanFail;
  logic [EW-1:0]   w_codeLat [NCH];
  logic            w_term;
  logic            w_wdHit;
  logic            w_anyFail;
  logic [CHW-1:0]  w_failIdx;
  logic [EW-1:0]   w_failCode;

  // Requests are only taken while running and before a stop decision;
  // the decision itself takes effect one edge later.
  assign w_en = (r_state == ST_RUN) && !r_stop;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_finish[gi] = arg[gi*SW + EW];

      ext_exit_chan #(.EW(EW)) u_chan (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .en       (w_en),
        .finish   (w_finish[gi]),
        .exitcode (arg[gi*SW +: EW]),
        .fin      (w_fin[gi]),
        .code     (w_codeLat[gi])
      );

      assign w_accept[gi]   = w_en && w_finish[gi] && !w_fin[gi];
      assign w_chanFail[gi] = w_fin[gi] && (w_codeLat[gi] != '0);
    end
  endgenerate

  // The terminate test includes channels finishing on this very edge.
  assign w_finNext = w_fin | w_accept;
  assign w_term    = w_en && ((MODE == 0) ? (&w_finNext) : (|w_finNext));
  assign w_wdHit   = (TIMEOUT != 0) && w_en && !w_term && (r_wdCnt == WD_LAST);

  // Lowest-index failing channel: scanning downwards lets lower indices
  // overwrite higher ones. Failures are seen one edge after latching, so
  // failures from different cycles are still recorded in arrival order.
  always_comb begin
    w_anyFail  = 1'b0;
    w_failIdx  = '0;
    w_failCode = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_chanFail[i]) begin
        w_anyFail  = 1'b1;
        w_failIdx  = CHW'(i);
        w_failCode = w_codeLat[i];
      end
    end
  end

  // Controller: RUN collects results and runs the watchdog, DRAIN counts
  // down, DONE holds the verdict until reset. A watchdog expiry overrides
  // any failure recorded earlier.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_RUN;
      r_stop     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_timeout  <= 1'b0;
      r_chan     <= '0;
      r_code     <= '0;
      r_drainCnt <= '0;
      r_wdCnt    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!r_stop && (r_wdCnt != '1)) begin
            r_wdCnt <= r_wdCnt + 32'd1;
          end
          if (w_wdHit) begin
            r_stop    <= 1'b1;
            r_timeout <= 1'b1;
            r_fail    <= 1'b1;
            r_chan    <= '0;
            r_code    <= '1;
          end else begin
            if (w_term) begin
              r_stop <= 1'b1;
            end
            if (!r_fail && w_anyFail) begin
              r_fail <= 1'b1;
              r_chan <= w_failIdx;
              r_code <= w_failCode;
            end
          end
          if (r_stop) begin
            r_state    <= ST_DRAIN;
            r_drainCnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drainCnt == 8'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt - 8'd1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef SIMULATION
  // Report the verdict on the edge that enters DONE, then end the run.
  always_ff @(posedge CLK) begin
    if (RST_N && (r_state == ST_DRAIN) && (r_drainCnt == 8'd0)) begin
      if (!r_fail) begin
        $display("PASS");
      end else if (r_timeout) begin
        $display("FAIL (timeout)");
      end else begin
        $display("FAIL (chan %0d, code %0d)", r_chan, r_code);
      end
      $finish;
    end
  end
`endif

  assign out = {r_done, r_fail, r_timeout, r_chan, r_code};

endmodule

// File: tb/tb_ext_exit_ctrl.sv
// tb_ext_exit_ctrl
// Directed bench for the exit controller. Three instances cover the
// ALL/ANY policies, drain lengths and the watchdog; each scenario resets
// everything and counts cycles from the first edge after reset release.
module tb_ext_exit_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [17:0] argA;
  logic [35:0] argB;
  logic [17:0] argC;
  logic [11:0] outA;
  logic [12:0] outB;
  logic [11:0] outC;
  logic [35:0] vecB;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 CLK = ~CLK;

  ext_exit_ctrl #(.NCH(2), .EW(8), .MODE(0), .DRAIN(4), .TIMEOUT(100)) dutA (
    .CLK   (CLK),
    .RST_N (RST_N),
    .arg   (argA),
    .out   (outA)
  );

  ext_exit_ctrl #(.NCH(4), .EW(8), .MODE(0), .DRAIN(4), .TIMEOUT(0)) dutB (
    .CLK   (CLK),
    .RST_N (RST_N),
    .arg   (argB),
    .out   (outB)
  );

  ext_exit_ctrl #(.NCH(2), .EW(8), .MODE(1), .DRAIN(1), .TIMEOUT(0)) dutC (
    .CLK   (CLK),
    .RST_N (RST_N),
    .arg   (argC),
    .out   (outC)
  );

  // One rising edge, then settle 1 time unit so outputs are sampled away
  // from the edge and new inputs land well before the next one.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Advance until the next edge is cycle c.
  task automatic runTo(input int c);
    while (cyc < c) tick();
  endtask

  task automatic resetAll();
    RST_N = 1'b0;
    argA  = '0;
    argB  = '0;
    argC  = '0;
    tick();
    tick();
    RST_N = 1'b1;
    cyc   = 0;
  endtask

  // Present a request vector to one instance for exactly one edge.
  task automatic applyStimulus(input int sel, input logic [35:0] value);
    case (sel)
      0:       argA = value[17:0];
      1:       argB = value;
      default: argC = value[17:0];
    endcase
    tick();
    argA = '0;
    argB = '0;
    argC = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Directed scenarios, each starting from a fresh reset.
  initial begin
    // ALL mode pass: ch0 at 10 (repeat with code 4 at 12 is ignored), ch1 at 20.
    resetAll();
    checkOutput("A reset", 16'(outA), 16'h000);
    checkOutput("B reset", 16'(outB), 16'h0000);
    checkOutput("C reset", 16'(outC), 16'h000);
    runTo(10);
    applyStimulus(0, 36'h100);
    runTo(12);
    applyStimulus(0, 36'h104);
    runTo(20);
    checkOutput("A repeat ignored", 16'(outA), 16'h000);
    applyStimulus(0, 36'h20000);
    runTo(25);
    checkOutput("A before done", 16'(outA), 16'h000);
    tick();
    checkOutput("A done pass", 16'(outA), 16'h800);
    runTo(40);
    checkOutput("A done holds", 16'(outA), 16'h800);

    // Failure recorded, reset mid-drain aborts, fresh run completes.
    resetAll();
    runTo(3);
    applyStimulus(0, 36'h112);
    applyStimulus(0, 36'h20000);
    checkOutput("A fail ch0", 16'(outA), 16'h412);
    tick();
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    checkOutput("A abort", 16'(outA), 16'h000);
    cyc = 0;
    runTo(2);
    checkOutput("A no stale done", 16'(outA), 16'h000);
    applyStimulus(0, 36'h24200);
    runTo(5);
    checkOutput("A fail ch1", 16'(outA), 16'h521);
    applyStimulus(0, 36'h100);
    runTo(10);
    checkOutput("A rerun before done", 16'(outA), 16'h521);
    tick();
    checkOutput("A rerun done", 16'(outA), 16'hD21);

    // Watchdog expiry with no requests.
    resetAll();
    runTo(99);
    checkOutput("A pre-timeout", 16'(outA), 16'h000);
    tick();
    checkOutput("A timeout", 16'(outA), 16'h6FF);
    runTo(104);
    checkOutput("A timeout before done", 16'(outA), 16'h6FF);
    tick();
    checkOutput("A timeout done", 16'(outA), 16'hEFF);

    // Last finish on the watchdog's final cycle: terminate wins.
    resetAll();
    runTo(50);
    applyStimulus(0, 36'h100);
    runTo(99);
    applyStimulus(0, 36'h20000);
    checkOutput("A no timeout", 16'(outA), 16'h000);
    runTo(104);
    checkOutput("A late before done", 16'(outA), 16'h000);
    tick();
    checkOutput("A late done", 16'(outA), 16'h800);

    // Four channels, simultaneous failures on ch1 and ch3: lowest index wins.
    resetAll();
    runTo(3);
    vecB = '0;
    vecB[9 +: 9]  = 9'h105;
    vecB[27 +: 9] = 9'h107;
    applyStimulus(1, vecB);
    runTo(6);
    vecB = '0;
    vecB[0 +: 9]  = 9'h100;
    vecB[18 +: 9] = 9'h100;
    applyStimulus(1, vecB);
    checkOutput("B lowest fail", 16'(outB), 16'h0905);
    runTo(11);
    checkOutput("B before done", 16'(outB), 16'h0905);
    tick();
    checkOutput("B done", 16'(outB), 16'h1905);

    // ANY mode, one-cycle drain: ch1 at 5 ends the run, ch0 at 6 ignored.
    resetAll();
    runTo(5);
    applyStimulus(2, 36'h20600);
    applyStimulus(2, 36'h109);
    checkOutput("C first wins", 16'(outC), 16'h503);
    tick();
    checkOutput("C done", 16'(outC), 16'hD03);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
